// File: rtl/vga_scan_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_fetch
// Purpose  : VGA raster timing generator with frame-memory fetch. Scans an
//            H_TOT x V_TOT raster, issues linear read addresses for the pixels
//            inside an IMG_W x IMG_H image window anchored at (0,0), and
//            re-aligns sync/blank flags with the returned pixel data so the
//            display outputs are fully registered and mutually consistent.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   pixel clock, all logic on the rising edge
//   resetN      in   synchronous active-low reset
//   enable      in   scan enable; while low the raster is parked at (0,0)
//   R, G, B     in   [7:0] frame-memory data, valid the cycle after pxlAddr/re
//   pxlAddr     out  [17:0] frame-memory read address (row*IMG_W + col)
//   re          out  frame-memory read enable, high only inside the image
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   blankN      out  high while the displayed pixel is in the visible area
//   vgaR/G/B    out  [7:0] display colour
//   frameStart  out  one-cycle pulse coincident with pixel (0,0) on the outputs
// ============================================================================
module vga_scan_fetch #(
  parameter int          H_VIS   = 640,
  parameter int          H_FP    = 16,
  parameter int          H_SYNC  = 96,
  parameter int          H_BP    = 48,
  parameter int          V_VIS   = 480,
  parameter int          V_FP    = 10,
  parameter int          V_SYNC  = 2,
  parameter int          V_BP    = 33,
  parameter int          IMG_W   = 512,
  parameter int          IMG_H   = 480,
  parameter logic [23:0] BORDER  = 24'h000000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic [17:0] pxlAddr,
  output logic        re,
  output logic        hsync,
  output logic        vsync,
  output logic        blankN,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB,
  output logic        frameStart
);

  // --------------------------------------------------------------------------
  // Raster geometry
  // --------------------------------------------------------------------------
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] IMG_W_C  = HW'(IMG_W);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC - 1);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] IMG_H_C  = VW'(IMG_H);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC - 1);

  // Bit positions inside the flag vectors carried down the pipeline
  localparam int F_VIS   = 0;
  localparam int F_IMG   = 1;
  localparam int F_HS    = 2;
  localparam int F_VS    = 3;
  localparam int F_FIRST = 4;
  localparam int NFLAGS  = 5;

  // --------------------------------------------------------------------------
  // Stage 0: raster counters and linear address counter
  // --------------------------------------------------------------------------
  logic [HW-1:0] hCnt_q, hCnt_d;
  logic [VW-1:0] vCnt_q, vCnt_d;
  logic [17:0]   addr_q, addr_d;
  logic          hWrap;
  logic          vWrap;
  logic          atOrigin;
  logic [17:0]   addrCur;
  logic [NFLAGS-1:0] flags0;

  assign hWrap    = (hCnt_q == H_LAST);
  assign vWrap    = (vCnt_q == V_LAST);
  assign atOrigin = (hCnt_q == '0) && (vCnt_q == '0);

  always_comb begin
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (!enable) begin
      // Parked at the origin so that re-enabling starts a fresh frame.
      hCnt_d = '0;
      vCnt_d = '0;
    end else begin
      hCnt_d = hWrap ? '0 : hCnt_q + HW'(1);
      if (hWrap) begin
        vCnt_d = vWrap ? '0 : vCnt_q + VW'(1);
      end
    end
  end

  // Stage-0 flags. All are gated by enable: the parked counters sit at (0,0),
  // which would otherwise look like a visible, in-image first pixel.
  always_comb begin
    flags0          = '0;
    flags0[F_VIS]   = enable && (hCnt_q < H_VIS_C) && (vCnt_q < V_VIS_C);
    flags0[F_IMG]   = flags0[F_VIS] && (hCnt_q < IMG_W_C) && (vCnt_q < IMG_H_C);
    flags0[F_HS]    = enable && (hCnt_q >= HS_BEG) && (hCnt_q <= HS_END);
    flags0[F_VS]    = enable && (vCnt_q >= VS_BEG) && (vCnt_q <= VS_END);
    flags0[F_FIRST] = enable && atOrigin;
  end

  // The image rows are contiguous in memory, so simply counting in-image
  // pixels in raster order yields row*IMG_W + col without a multiplier.
  // The counter is forced to 0 at the origin so every frame restarts cleanly.
  assign addrCur = atOrigin ? 18'd0 : addr_q;

  always_comb begin
    addr_d = addrCur + {17'd0, flags0[F_IMG]};
    if (!enable) begin
      addr_d = 18'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: memory request
  // --------------------------------------------------------------------------
  logic [17:0] pxlAddr_q, pxlAddr_d;
  logic        re_q, re_d;

  always_comb begin
    re_d      = flags0[F_IMG];
    // Address holds its last value outside the image window.
    pxlAddr_d = flags0[F_IMG] ? addrCur : pxlAddr_q;
  end

  // --------------------------------------------------------------------------
  // Flag delay chain. Memory data for a stage-0 pixel arrives in stage 2,
  // so the flags ride two registers and the output register forms stage 3.
  // --------------------------------------------------------------------------
  logic [NFLAGS-1:0] s1_q;
  logic [NFLAGS-1:0] s2_q;

  // --------------------------------------------------------------------------
  // Stage 3: display output registers
  // --------------------------------------------------------------------------
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blankN_q, blankN_d;
  logic        frameStart_q, frameStart_d;
  logic [23:0] colour_q, colour_d;

  always_comb begin
    hsync_d      = ~s2_q[F_HS];
    vsync_d      = ~s2_q[F_VS];
    blankN_d     = s2_q[F_VIS];
    frameStart_d = s2_q[F_FIRST];
    colour_d     = 24'h000000;
    if (s2_q[F_IMG]) begin
      colour_d = {R, G, B};
    end else if (s2_q[F_VIS]) begin
      colour_d = BORDER;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetN) begin
      hCnt_q       <= '0;
      vCnt_q       <= '0;
      addr_q       <= 18'd0;
      pxlAddr_q    <= 18'd0;
      re_q         <= 1'b0;
      s1_q         <= '0;
      s2_q         <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      blankN_q     <= 1'b0;
      frameStart_q <= 1'b0;
      colour_q     <= 24'h000000;
    end else begin
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      addr_q       <= addr_d;
      pxlAddr_q    <= pxlAddr_d;
      re_q         <= re_d;
      s1_q         <= flags0;
      s2_q         <= s1_q;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      blankN_q     <= blankN_d;
      frameStart_q <= frameStart_d;
      colour_q     <= colour_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pxlAddr    = pxlAddr_q;
  assign re         = re_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign blankN     = blankN_q;
  assign frameStart = frameStart_q;
  assign vgaR       = colour_q[23:16];
  assign vgaG       = colour_q[15:8];
  assign vgaB       = colour_q[7:0];

endmodule
`default_nettype wire

// File: doc/vga_scan_fetch.md
VGA_SCAN_FETCH -- requirements
Module: vga_scan_fetch

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_VIS 640 visible columns; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch; V_VIS 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; IMG_W 512 image width; IMG_H 480 image height; BORDER 24'h000000 colour outside image.
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  pixel clock, all logic on posedge.
  resetN  in  1  reset, synchronous, active-low.
  enable  in  1  scan enable.
  R, G, B  in  8 each  pixel data from frame memory, valid the cycle after its address is sampled.
  pxlAddr  out  18  frame-memory read address.
  re  out  1  frame-memory read enable.
  hsync, vsync  out  1 each  active-low sync.
  blankN  out  1  high in visible area.
  vgaR, vgaG, vgaB  out  8 each  display colour.
  frameStart  out  1  one-cycle pulse with pixel (0,0) on display outputs.

Function
REQ-003 SHALL hold hCnt 0..H_TOT-1 (H_TOT=H_VIS+H_FP+H_SYNC+H_BP=800), incrementing each enabled cycle, wrapping to 0.
REQ-004 SHALL hold vCnt 0..V_TOT-1 (V_TOT=525), incrementing when hCnt wraps, wrapping to 0 when both wrap in the same cycle.
REQ-005 SHALL define stage-0 flags from (hCnt,vCnt): vis = hCnt<H_VIS and vCnt<V_VIS; inImg = vis and hCnt<IMG_W and vCnt<IMG_H; hs = hCnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] (656..751); vs = vCnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] (490..491).
REQ-006 SHALL keep an 18-bit linear address counter: cleared when (hCnt,vCnt)=(0,0), incremented after each inImg cycle; address = row*IMG_W+col with no multiplier.
REQ-007 SHALL register pxlAddr=current address counter and re=inImg one cycle after stage 0 (stage 1); pxlAddr holds its last value when re=0.
REQ-008 SHALL delay vis, inImg, hs, vs and first-pixel flag by a 3-stage register chain so display outputs align with memory data.
REQ-009 SHALL register display outputs at stage 3: hsync=~hs, vsync=~vs, blankN=vis, frameStart=first-pixel flag; colour = {R,G,B} if inImg, BORDER if vis and not inImg, 0 otherwise.
REQ-010 SHALL give total latency: pxlAddr/re 1 cycle, display outputs 3 cycles after stage-0 counter state.
REQ-011 SHALL, when enable=0: hold hCnt=vCnt=0, address counter 0, re=0; pipeline continues flushing so display outputs reach idle values (hsync=1, vsync=1, blankN=0, colour 0, frameStart=0) within 3 cycles.
REQ-012 SHALL, on enable rising, start from (0,0); first frameStart 3 cycles after first enabled cycle.
REQ-013 SHALL never assert re outside the image window; maximum pxlAddr = IMG_W*IMG_H-1 (245759 at defaults).
REQ-014 SHALL support IMG_W<=H_VIS, IMG_H<=V_VIS, IMG_W*IMG_H<=262144; other values are illegal configurations.

Reset
REQ-015 SHALL, on clk edge with resetN=0, clear hCnt, vCnt, address counter, all pipeline flags; pxlAddr=0, re=0, hsync=1, vsync=1, blankN=0, vgaR/G/B=0, frameStart=0.
REQ-016 SHALL give reset priority over enable; reset mid-frame restarts at (0,0) on the first cycle with resetN=1 and enable=1.

Verification
REQ-017 Reset then enable=1 -> pxlAddr=0,re=1 at cycle 1; frameStart=1, blankN=1 at cycle 3; frameStart pulses every 420000 cycles.
REQ-018 Full line -> hsync low exactly 96 cycles, falling 656 cycles after line-start on outputs; line period 800 cycles.
REQ-019 Full frame -> vsync low for 2 lines (1600 cycles), starting at line 490; re high 512 cycles per line for lines 0..479; last pxlAddr 245759.
REQ-020 Memory model returning R=addr[7:0] with 1-cycle latency -> vgaR at column 5, line 1 equals (512+5)&255=5; columns 512..639 show BORDER; blanking shows 0.
REQ-021 Deassert enable mid-line -> re=0 next cycle, outputs idle within 3 cycles; reassert -> restart at pxlAddr=0.
REQ-022 resetN=0 for one cycle mid-frame -> all outputs at reset values next cycle, frame restarts from (0,0).
